// File: rtl/sa_out_drain.sv
// Result-drain stage behind the systolic array: captures or accumulates result tiles
// (saturating), then streams the finished tile out one row per valid/ready handshake.
module sa_out_drain #(
    parameter int D_W  = 16,
    parameter int SA_R = 16,
    parameter int SA_C = 16,
    parameter int RW   = $clog2(SA_R)
) (
    input  logic                                 I_CLK,
    input  logic                                 I_RSTN,
    input  logic                                 I_IN_VLD,
    input  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]   I_IN_DATA,
    input  logic                                 I_ACC,
    input  logic                                 I_LAST,
    output logic                                 O_IN_RDY,
    output logic                                 O_DROP,
    output logic                                 O_SAT,
    output logic                                 O_ROW_VLD,
    input  logic                                 I_ROW_RDY,
    output logic [SA_C-1:0][D_W-1:0]             O_ROW_DATA,
    output logic [RW-1:0]                        O_ROW_IDX,
    output logic                                 O_ROW_LAST,
    output logic                                 O_BUSY,
    output logic [1:0]                           O_DBG_STATE
);

    // Row handshake: a row transfers on any rising edge where O_ROW_VLD && I_ROW_RDY;
    // while O_ROW_VLD is high and I_ROW_RDY is low, row data/index/last hold stable.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                               r_state;
    state_t                               w_next_state;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]   r_buf;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]   w_sum;
    logic [SA_R-1:0][SA_C-1:0][D_W:0]     w_ext;
    logic [RW-1:0]                        r_row;
    logic                                 r_row_vld;
    logic                                 r_drop;
    logic                                 r_sat;
    logic                                 w_in_rdy;
    logic                                 w_cap;
    logic                                 w_acc_en;
    logic                                 w_sat_any;
    logic                                 w_hs;
    logic                                 w_last_row;

    assign w_in_rdy   = (r_state != S_DRAIN);
    assign w_cap      = I_IN_VLD && w_in_rdy;
    assign w_acc_en   = (r_state == S_HOLD) && I_ACC;
    assign w_hs       = r_row_vld && I_ROW_RDY;
    assign w_last_row = (r_row == RW'(SA_R - 1));

    // Elementwise add on D_W+1 bits; disagreeing top bits mean overflow, clamp by sign.
    always_comb begin
        w_sat_any = 1'b0;
        w_sum     = '0;
        w_ext     = '0;
        for (int r = 0; r < SA_R; r++) begin
            for (int c = 0; c < SA_C; c++) begin
                w_ext[r][c] = {r_buf[r][c][D_W-1], r_buf[r][c]} +
                              {I_IN_DATA[r][c][D_W-1], I_IN_DATA[r][c]};
                if (w_ext[r][c][D_W] != w_ext[r][c][D_W-1]) begin
                    w_sat_any   = 1'b1;
                    w_sum[r][c] = w_ext[r][c][D_W] ? {1'b1, {(D_W-1){1'b0}}}
                                                   : {1'b0, {(D_W-1){1'b1}}};
                end else begin
                    w_sum[r][c] = w_ext[r][c][D_W-1:0];
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_HOLD: begin
                if (w_cap) w_next_state = I_LAST ? S_DRAIN : S_HOLD;
            end
            S_DRAIN: begin
                if (w_hs && w_last_row) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RSTN) begin
            r_state   <= S_IDLE;
            r_buf     <= '0;
            r_row     <= '0;
            r_row_vld <= 1'b0;
            r_drop    <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_drop  <= I_IN_VLD && !w_in_rdy;
            if (w_cap) begin
                r_buf <= w_acc_en ? w_sum : I_IN_DATA;
                if (I_LAST) begin
                    r_row     <= '0;
                    r_row_vld <= 1'b1;
                    r_sat     <= w_acc_en && w_sat_any;
                end else begin
                    r_sat     <= r_sat || (w_acc_en && w_sat_any);
                end
            end
            if (w_hs) begin
                if (w_last_row) begin
                    r_row     <= '0;
                    r_row_vld <= 1'b0;
                end else begin
                    r_row     <= r_row + 1'b1;
                end
            end
        end
    end

    assign O_IN_RDY    = w_in_rdy;
    assign O_DROP      = r_drop;
    assign O_SAT       = r_sat;
    assign O_ROW_VLD   = r_row_vld;
    assign O_ROW_DATA  = r_buf[r_row];
    assign O_ROW_IDX   = r_row;
    assign O_ROW_LAST  = r_row_vld && w_last_row;
    assign O_BUSY      = (r_state != S_IDLE);
    assign O_DBG_STATE = r_state;

endmodule

// File: tb/tb_sa_out_drain.sv
// Bench for sa_out_drain: directed tiles, row scoreboard fed at issue time and a
// negedge monitor that pops on every row handshake.
module tb_sa_out_drain;

    localparam int D_W  = 16;
    localparam int SA_R = 16;
    localparam int SA_C = 16;
    localparam int RW   = 4;
    localparam int W    = 1 + RW + SA_C * D_W;

    typedef logic [SA_R-1:0][SA_C-1:0][D_W-1:0] tile_t;
    typedef logic [SA_C-1:0][D_W-1:0]           row_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_vld;
    tile_t         in_data;
    logic          acc;
    logic          last;
    logic          in_rdy;
    logic          drop;
    logic          sat;
    logic          row_vld;
    logic          row_rdy;
    row_t          row_data;
    logic [RW-1:0] row_idx;
    logic          row_last;
    logic          busy;
    logic [1:0]    dbg_state;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    sa_out_drain #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) dut (
        .I_CLK(clk), .I_RSTN(rstn), .I_IN_VLD(in_vld), .I_IN_DATA(in_data),
        .I_ACC(acc), .I_LAST(last), .O_IN_RDY(in_rdy), .O_DROP(drop), .O_SAT(sat),
        .O_ROW_VLD(row_vld), .I_ROW_RDY(row_rdy), .O_ROW_DATA(row_data),
        .O_ROW_IDX(row_idx), .O_ROW_LAST(row_last), .O_BUSY(busy),
        .O_DBG_STATE(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    function automatic tile_t fill(input logic [D_W-1:0] v);
        tile_t t;
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++) t[r][c] = v;
        return t;
    endfunction

    // Element (r,c) = base + r*16 + c, so row 5 col 3 of base 0 is 0x0053.
    function automatic tile_t pattern(input logic [D_W-1:0] base);
        tile_t t;
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++) t[r][c] = base + D_W'(r * 16 + c);
        return t;
    endfunction

    function automatic tile_t rows_alt(input logic [D_W-1:0] ev, input logic [D_W-1:0] od);
        tile_t t;
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++) t[r][c] = r[0] ? od : ev;
        return t;
    endfunction

    function automatic logic [W-1:0] pack_row(input tile_t t, input int r);
        return {(r == SA_R - 1), RW'(r), t[r]};
    endfunction

    task automatic push_rows(input tile_t t, input int n);
        for (int r = 0; r < n; r++) exp_q.push_back(pack_row(t, r));
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- driver tasks (entered/exited at posedge+1) ----------------
    task automatic send_tile(input tile_t t, input logic a, input logic l);
        in_data = t;
        acc     = a;
        last    = l;
        in_vld  = 1'b1;
        @(posedge clk); #1;
        in_vld  = 1'b0;
        acc     = 1'b0;
        last    = 1'b0;
    endtask

    // Runs one drain; stalls row_rdy for cycles [st, st+sl) and pulses in_vld at cycle dr.
    task automatic run_drain(input int st, input int sl, input int dr,
                             input int stall_row, input int exp_cycles, input int exp_drops);
        int cycles = 0;
        int drops  = 0;
        tile_t junk = fill(16'h5A5A);
        for (int k = 0; k < 64; k++) begin
            row_rdy = !(k >= st && k < st + sl);
            if (k == dr) begin
                in_data = junk;
                in_vld  = 1'b1;
            end else begin
                in_vld  = 1'b0;
            end
            @(negedge clk);
            if (drop) drops++;
            if (k == 0) chk("first_row_vld", W'(row_vld), W'(1));
            if (!row_vld) break;
            cycles++;
            if (!row_rdy) chk("stall_row_idx", W'(row_idx), W'(stall_row));
            @(posedge clk); #1;
        end
        chk("drain_cycles", W'(cycles), W'(exp_cycles));
        chk("drop_pulses", W'(drops), W'(exp_drops));
        chk("in_rdy_after_drain", W'(in_rdy), W'(1));
        chk("busy_after_drain", W'(busy), W'(0));
        @(posedge clk); #1;
        in_vld  = 1'b0;
        row_rdy = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rstn === 1'b1 && row_vld === 1'b1 && row_rdy === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_row actual_idx=%0d", row_idx);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({row_last, row_idx, row_data} !== e) begin
                    errors++;
                    $display("FAIL row actual=%0h required=%0h",
                             {row_last, row_idx, row_data}, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        tile_t t;
        rstn    = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        acc     = 1'b0;
        last    = 1'b0;
        row_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_in_rdy", W'(in_rdy), W'(1));
        chk("rst_row_vld", W'(row_vld), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_sat", W'(sat), W'(0));
        chk("rst_drop", W'(drop), W'(0));
        chk("rst_state", W'(dbg_state), W'(0));
        @(posedge clk); #1;

        // Single tile, straight drain.
        t = pattern(16'h0000);
        push_rows(t, SA_R);
        send_tile(t, 1'b0, 1'b1);
        run_drain(-10, 0, -1, 0, 16, 0);

        // Accumulate 0x2000 + 0x1000.
        send_tile(fill(16'h2000), 1'b0, 1'b0);
        @(negedge clk);
        chk("hold_busy", W'(busy), W'(1));
        chk("hold_in_rdy", W'(in_rdy), W'(1));
        chk("hold_row_vld", W'(row_vld), W'(0));
        @(posedge clk); #1;
        push_rows(fill(16'h3000), SA_R);
        send_tile(fill(16'h1000), 1'b1, 1'b1);
        run_drain(-10, 0, -1, 0, 16, 0);
        chk("acc_no_sat", W'(sat), W'(0));

        // Restart inside HOLD with I_ACC=0.
        send_tile(fill(16'h1111), 1'b0, 1'b0);
        push_rows(fill(16'h0123), SA_R);
        send_tile(fill(16'h0123), 1'b0, 1'b1);
        run_drain(-10, 0, -1, 0, 16, 0);

        // Saturation both directions.
        send_tile(rows_alt(16'h6000, 16'hA000), 1'b0, 1'b0);
        push_rows(rows_alt(16'h7FFF, 16'h8000), SA_R);
        send_tile(rows_alt(16'h6000, 16'hA000), 1'b1, 1'b1);
        run_drain(-10, 0, -1, 0, 16, 0);
        chk("sat_sticky", W'(sat), W'(1));

        // Backpressure on row 2 for 3 cycles; new drain start clears O_SAT.
        t = pattern(16'h1000);
        push_rows(t, SA_R);
        send_tile(t, 1'b0, 1'b1);
        run_drain(2, 3, -1, 2, 19, 0);
        chk("sat_cleared", W'(sat), W'(0));

        // Drop during row 7: rows keep original data.
        t = pattern(16'h2000);
        push_rows(t, SA_R);
        send_tile(t, 1'b0, 1'b1);
        run_drain(-10, 0, 7, 0, 16, 1);

        // Tile arriving with the last-row handshake is dropped too.
        t = pattern(16'h3000);
        push_rows(t, SA_R);
        send_tile(t, 1'b0, 1'b1);
        run_drain(-10, 0, 15, 0, 16, 1);
        @(negedge clk);
        chk("last_hs_drop_idle", W'(busy), W'(0));
        @(posedge clk); #1;

        // Reset mid-drain at row 4.
        t = pattern(16'h0400);
        push_rows(t, 4);
        send_tile(t, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        row_rdy = 1'b0;
        rstn    = 1'b0;
        @(negedge clk);
        chk("pre_rst_idx", W'(row_idx), W'(4));
        @(posedge clk); #1;
        rstn    = 1'b1;
        row_rdy = 1'b1;
        @(negedge clk);
        chk("post_rst_row_vld", W'(row_vld), W'(0));
        chk("post_rst_in_rdy", W'(in_rdy), W'(1));
        chk("post_rst_busy", W'(busy), W'(0));
        @(posedge clk); #1;
        t = pattern(16'h0700);
        push_rows(t, SA_R);
        send_tile(t, 1'b0, 1'b1);
        run_drain(-10, 0, -1, 0, 16, 0);

        chk("exp_q_empty", W'(exp_q.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_out_drain.md
Name: sa_out_drain

Overview:
- Result-drain stage directly downstream of the systolic-array wrapper.
- Captures the full SA_R x SA_C result tile on the wrapper's one-cycle output-valid pulse.
- Optionally accumulates successive K-split partial tiles with signed saturation.
- Streams the finished tile out one row per handshake over valid/ready to the next MHA stage (softmax / writeback).

Parameters:
- D_W, 16, element width; signed fixed-point, 1 sign, 2 int, 13 frac bits.
- SA_R, 16, tile rows; equals the array row count.
- SA_C, 16, tile columns; equals the array column count.

Ports:
- I_CLK  in  1  clock; all logic on posedge.
- I_RSTN  in  1  reset; synchronous, active-low.
- I_IN_VLD  in  1  tile-valid pulse; wired to the array wrapper's O_OUT_VLD.
- I_IN_DATA  in  D_W x [SA_R][SA_C]  result tile; sampled only when I_IN_VLD=1.
- I_ACC  in  1  when 1, add the incoming tile to the held buffer instead of overwriting it.
- I_LAST  in  1  when 1, this tile completes the result; start draining after capture.
- O_IN_RDY  out  1  block can accept a tile this cycle.
- O_DROP  out  1  one-cycle pulse: I_IN_VLD arrived while O_IN_RDY=0; that tile is discarded.
- O_SAT  out  1  sticky flag: any element saturated since the last drain started.
- O_ROW_VLD  out  1  row output valid.
- I_ROW_RDY  in  1  downstream accepts the row.
- O_ROW_DATA  out  D_W x [SA_C]  current row.
- O_ROW_IDX  out  $clog2(SA_R)  index of the current row, 0..SA_R-1.
- O_ROW_LAST  out  1  high with O_ROW_VLD when O_ROW_IDX==SA_R-1.
- O_BUSY  out  1  high in S_HOLD or S_DRAIN.

Behaviour:
- Reset (I_RSTN=0 at a clock edge):
  - Outputs: state=S_IDLE, buffer=0, row counter=0, O_ROW_VLD=0, O_DROP=0, O_SAT=0, O_BUSY=0, O_IN_RDY=1.
  - Reset overrides everything, including a drain in progress; no partial row is emitted afterwards.
- States:
  - S_IDLE: buffer empty; O_IN_RDY=1.
  - S_HOLD: partial tile held; O_IN_RDY=1.
  - S_DRAIN: streaming rows; O_IN_RDY=0.
- Capture (I_IN_VLD && O_IN_RDY):
  - In S_IDLE, I_ACC is ignored and buf<=I_IN_DATA.
  - In S_HOLD with I_ACC=1, buf<=sat(buf+I_IN_DATA); with I_ACC=0, buf<=I_IN_DATA (restart).
  - If I_LAST=1, next state is S_DRAIN, row counter=0, O_SAT cleared and then set by this capture's saturation. Otherwise next state is S_HOLD.
- Saturating add:
  - Sign-extend both operands to D_W+1 bits and add.
  - Overflow (top two bits differ) clamps to 2^(D_W-1)-1 (0x7FFF) when positive, or -2^(D_W-1) (0x8000) when negative.
  - Any clamp sets O_SAT.
- Drain:
  - O_ROW_VLD is registered and asserted the cycle after the I_LAST capture (latency 1).
  - O_ROW_DATA = buf[row], O_ROW_IDX = row.
  - While O_ROW_VLD && !I_ROW_RDY, data, index and O_ROW_LAST hold stable.
  - On handshake, row increments; at row SA_R-1 the handshake moves to S_IDLE, O_ROW_VLD=0, and O_IN_RDY=1 from the next cycle.
  - Throughput: 1 row/cycle with I_ROW_RDY held high, so SA_R cycles per tile.
- Drop:
  - I_IN_VLD in S_DRAIN gives O_DROP=1 for one cycle.
  - Buffer and state are unchanged.
- Simultaneous events:
  - The last-row handshake and I_IN_VLD in the same cycle: the tile is dropped, because O_IN_RDY is still 0 that cycle.
  - I_IN_VLD=0 leaves I_ACC and I_LAST don't-care.
- Arithmetic is pure two's-complement; no rounding.

Test Plan:
- Single tile: tile[r][c]=r*16+c, I_LAST=1, I_ROW_RDY=1 -> O_ROW_VLD rises the next cycle; rows 0..15 on consecutive cycles; row 5 col 3 = 0x0053; O_ROW_LAST only on row 15; O_IN_RDY returns 1 after 16 rows.
- Accumulate: tile A all 0x2000 (I_LAST=0), then tile B all 0x1000 with I_ACC=1, I_LAST=1 -> every element 0x3000, O_SAT=0.
- Saturation: 0x6000 + 0x6000 -> 0x7FFF; 0xA000 + 0xA000 -> 0x8000; O_SAT=1 until the next drain start.
- Backpressure: I_ROW_RDY low for 3 cycles on row 2 -> O_ROW_IDX=2 and its data stable for 3 cycles; total drain = 19 cycles.
- Drop: I_IN_VLD during row 7 -> O_DROP pulses once; remaining rows are unchanged original data.
- Reset mid-drain: I_RSTN=0 at row 4 -> next cycle O_ROW_VLD=0, O_IN_RDY=1; a new tile then drains from row 0 with the new data.
